sample_capture: RTL and testbench
=================================

SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 Parameter DEPTH, 3584, number of sample locations in the attached 8-bit BRAM.
REQ-002 Parameter AW, 12, BRAM address width.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ARM  in  1  one-cycle pulse; start a capture.
REQ-006 SAMPLE_VALID  in  1  SAMPLE_DIN holds a new sample this cycle.
REQ-007 SAMPLE_DIN  in  8  probe sample.
REQ-008 TRIG_MASK / TRIG_VALUE  in  8 each  trigger match = ((SAMPLE_DIN ^ TRIG_VALUE) & TRIG_MASK) == 0.
REQ-009 POST_COUNT  in  AW  samples stored after the trigger sample.
REQ-010 READ_REQ  in  1  one-cycle pulse; start readout.
REQ-011 RD_VALID / RD_DATA  out  1 / 8  readout stream; RD_READY  in  1  consumer accept.
REQ-012 MEM_ADDR  out  AW; MEM_EN, MEM_WE  out  1; MEM_DIN  out  8; MEM_DOUT  in  8  BRAM port, read data one cycle after MEM_EN.
REQ-013 ARMED, TRIGGERED, DONE  out  1 each  status.

Function
REQ-014 States: IDLE, PRE, POST, DONE, RD_ADDR, RD_WAIT, RD_OUT.
REQ-015 ARM is honoured only in IDLE or DONE; it clears wr_ptr, wrapped flag and post counter, then enters PRE; ignored elsewhere.
REQ-016 PRE/POST: each SAMPLE_VALID cycle drives MEM_EN=MEM_WE=1, MEM_ADDR=wr_ptr, MEM_DIN=SAMPLE_DIN combinationally; wr_ptr increments next cycle.
REQ-017 wr_ptr wraps DEPTH-1 -> 0, never reaching DEPTH..4095; first wrap sets wrapped flag.
REQ-018 PRE: valid matching sample is written, sets TRIGGERED, enters POST (or DONE directly if POST_COUNT==0).
REQ-019 POST: counts written samples; after POST_COUNT samples enters DONE; POST_COUNT > DEPTH-1 is clamped to DEPTH-1.
REQ-020 Non-valid cycles write nothing and do not advance counters.
REQ-021 READ_REQ honoured only in DONE; start address = wr_ptr if wrapped else 0; length = DEPTH if wrapped else wr_ptr.
REQ-022 Length 0 (no samples): READ_REQ leaves FSM in DONE, RD_VALID never asserts.
REQ-023 RD_ADDR: MEM_EN=1, MEM_WE=0, MEM_ADDR=rd_ptr; RD_WAIT: one latency cycle; RD_OUT: RD_DATA=captured MEM_DOUT, RD_VALID=1 held stable until RD_READY.
REQ-024 On RD_VALID&RD_READY: rd_ptr advances (wrapping as REQ-017), remaining decrements; last word returns to DONE, else RD_ADDR.
REQ-025 ARM and READ_REQ together in DONE: ARM wins.
REQ-026 MEM_WE is never asserted outside PRE/POST; MEM_EN is 0 in IDLE and DONE.
REQ-027 ARMED=1 in PRE/POST; TRIGGERED=1 from trigger until next ARM or RST; DONE=1 in DONE and RD_* states.

Reset
REQ-028 RST forces IDLE from any state, including mid-capture and mid-readout, effective next edge.
REQ-029 After RST all outputs 0: RD_VALID, RD_DATA, MEM_*, ARMED, TRIGGERED, DONE; internal pointers, counters, wrapped flag 0.
REQ-030 RST does not clear BRAM contents.

Configuration
REQ-031 Macro SAMPLE_CAPTURE_TRIG_EDGE_EN defined: trigger requires match on current valid sample AND no match on previous valid sample (previous-match flag cleared by ARM/RST, so first sample after ARM may trigger).
REQ-032 Macro undefined: level trigger per REQ-018; no previous-sample register exists.

Verification
REQ-033 MASK=0xFF, VALUE=0x5A, POST_COUNT=3, ramp 0x00.. -> trigger at 0x5A, stores 0x5B..0x5D, DONE; readout 0x00..0x5D, 94 words, in order.
REQ-034 MASK=0x00, POST_COUNT=3583 -> first sample triggers, wr_ptr wraps to 0, readout 3584 words starting at address 0 in sample order.
REQ-035 Trigger after 5000 samples, POST_COUNT=10 -> wrapped; readout starts at wr_ptr, 3584 words, last word = trigger+10.
REQ-036 RD_READY toggled 1/0 randomly -> RD_DATA constant while RD_VALID&!RD_READY; no word lost or duplicated.
REQ-037 RST asserted mid-POST and mid-readout -> next cycle IDLE, all outputs 0; ARM then restarts cleanly.
REQ-038 Edge macro on, MASK=0x01, VALUE=0x01, samples 0x01,0x01,0x00,0x01 -> trigger on first sample; off -> also first; with samples 0x00,0x01 edge triggers on second.

Source files
------------

// File: rtl/sample_capture.sv
// Trigger-based sample capture into an external 8-bit single-port BRAM, with
// a ready/valid readout of the captured window in sample order.
// Optional feature: define SAMPLE_CAPTURE_TRIG_EDGE_EN for an edge trigger,
// which fires on a match only when the previous valid sample did not match.
module sample_capture #(
    parameter int unsigned DEPTH = 3584,
    parameter int unsigned AW    = 12
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ARM,
    input  logic          SAMPLE_VALID,
    input  logic [7:0]    SAMPLE_DIN,
    input  logic [7:0]    TRIG_MASK,
    input  logic [7:0]    TRIG_VALUE,
    input  logic [AW-1:0] POST_COUNT,
    input  logic          READ_REQ,
    output logic          RD_VALID,
    output logic [7:0]    RD_DATA,
    input  logic          RD_READY,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [7:0]    MEM_DIN,
    input  logic [7:0]    MEM_DOUT,
    output logic          ARMED,
    output logic          TRIGGERED,
    output logic          DONE
);

    typedef enum logic [2:0] {
        StIdle, StPre, StPost, StDone, StRdAddr, StRdWait, StRdOut
    } state_e;

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW:0]   DepthLen = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          wrapped_q, wrapped_d;
    logic [AW-1:0] post_cnt_q, post_cnt_d;
    logic          trig_q, trig_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [7:0]    rd_data_q, rd_data_d;

    logic          match;
    logic          trig_hit;
    logic          capturing;
    logic          wr_fire;
    logic          do_arm;
    logic [AW-1:0] post_lim;
    logic [AW-1:0] post_cnt_inc;
    logic [AW-1:0] wr_ptr_inc;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW:0]   rd_len;

    assign match        = ((SAMPLE_DIN ^ TRIG_VALUE) & TRIG_MASK) == 8'h00;
    assign capturing    = (state_q == StPre) || (state_q == StPost);
    assign wr_fire      = capturing && SAMPLE_VALID;
    assign do_arm       = ARM && ((state_q == StIdle) || (state_q == StDone));
    // A post-trigger window longer than the buffer would overwrite the trigger itself.
    assign post_lim     = (POST_COUNT > LastAddr) ? LastAddr : POST_COUNT;
    assign post_cnt_inc = post_cnt_q + 1'b1;
    assign wr_ptr_inc   = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
    assign rd_ptr_inc   = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
    assign rd_len       = wrapped_q ? DepthLen : {1'b0, wr_ptr_q};

`ifdef SAMPLE_CAPTURE_TRIG_EDGE_EN
    logic prev_match_q, prev_match_d;

    assign trig_hit = match && !prev_match_q;

    // Remember whether the last valid sample matched; ARM forgets history.
    always_comb begin
        prev_match_d = prev_match_q;
        if (do_arm) begin
            prev_match_d = 1'b0;
        end else if (wr_fire) begin
            prev_match_d = match;
        end
    end

    // Previous-match flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_match_q <= 1'b0;
        end else begin
            prev_match_q <= prev_match_d;
        end
    end
`else
    assign trig_hit = match;
`endif

    // Next-state, datapath updates and BRAM/readout outputs.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        post_cnt_d  = post_cnt_q;
        trig_d      = trig_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        rd_data_d   = rd_data_q;
        MEM_EN      = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_DIN     = '0;
        RD_VALID    = 1'b0;

        if (wr_fire) begin
            MEM_EN   = 1'b1;
            MEM_WE   = 1'b1;
            MEM_ADDR = wr_ptr_q;
            MEM_DIN  = SAMPLE_DIN;
            wr_ptr_d = wr_ptr_inc;
            if (wr_ptr_q == LastAddr) begin
                wrapped_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: ;
            StPre: begin
                if (wr_fire && trig_hit) begin
                    trig_d  = 1'b1;
                    state_d = (post_lim == '0) ? StDone : StPost;
                end
            end
            StPost: begin
                if (wr_fire) begin
                    post_cnt_d = post_cnt_inc;
                    if (post_cnt_inc >= post_lim) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // An empty buffer leaves nothing to stream, so stay put.
                if (!ARM && READ_REQ && (rd_len != '0)) begin
                    rd_ptr_d    = wrapped_q ? wr_ptr_q : '0;
                    remaining_d = rd_len;
                    state_d     = StRdAddr;
                end
            end
            StRdAddr: begin
                MEM_EN   = 1'b1;
                MEM_ADDR = rd_ptr_q;
                state_d  = StRdWait;
            end
            StRdWait: begin
                rd_data_d = MEM_DOUT;
                state_d   = StRdOut;
            end
            StRdOut: begin
                RD_VALID = 1'b1;
                if (RD_READY) begin
                    rd_ptr_d    = rd_ptr_inc;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == (AW + 1)'(1)) ? StDone : StRdAddr;
                end
            end
            default: state_d = StIdle;
        endcase

        // ARM overrides any readout request made in the same cycle.
        if (do_arm) begin
            wr_ptr_d   = '0;
            wrapped_d  = 1'b0;
            post_cnt_d = '0;
            trig_d     = 1'b0;
            state_d    = StPre;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            post_cnt_q  <= '0;
            trig_q      <= 1'b0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            post_cnt_q  <= post_cnt_d;
            trig_q      <= trig_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign RD_DATA   = rd_data_q;
    assign ARMED     = capturing;
    assign TRIGGERED = trig_q;
    assign DONE      = (state_q == StDone) || (state_q == StRdAddr) ||
                       (state_q == StRdWait) || (state_q == StRdOut);

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture: randomized captures checked against
// a window model (last min(N, DEPTH) written samples), randomized RD_READY.
module tb_sample_capture;

    localparam int DEPTH = 3584;
    localparam int AW    = 12;

    logic          CLK = 1'b0;
    logic          RST, ARM, SAMPLE_VALID, READ_REQ, RD_READY;
    logic [7:0]    SAMPLE_DIN, TRIG_MASK, TRIG_VALUE, MEM_DOUT, RD_DATA, MEM_DIN;
    logic [AW-1:0] POST_COUNT, MEM_ADDR;
    logic          RD_VALID, MEM_EN, MEM_WE, ARMED, TRIGGERED, DONE;

    logic [7:0] mem [0:4095];
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int passed = 0;
    int total  = 0;

    always #5 CLK = ~CLK;

    sample_capture #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .ARM(ARM), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_DIN(SAMPLE_DIN), .TRIG_MASK(TRIG_MASK), .TRIG_VALUE(TRIG_VALUE),
        .POST_COUNT(POST_COUNT), .READ_REQ(READ_REQ), .RD_VALID(RD_VALID),
        .RD_DATA(RD_DATA), .RD_READY(RD_READY), .MEM_ADDR(MEM_ADDR), .MEM_EN(MEM_EN),
        .MEM_WE(MEM_WE), .MEM_DIN(MEM_DIN), .MEM_DOUT(MEM_DOUT), .ARMED(ARMED),
        .TRIGGERED(TRIGGERED), .DONE(DONE)
    );

    // BRAM: registered read, output held between reads.
    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
            else        MEM_DOUT <= mem[MEM_ADDR];
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit is_match(logic [7:0] s, logic [7:0] m, logic [7:0] v);
        return ((s ^ v) & m) == 8'h00;
    endfunction

    // Number of samples the capture should store, or -1 if it never triggers.
    function automatic int model_written(logic [7:0] m, logic [7:0] v, int post);
        int lim;
        bit hit;
        lim = (post > DEPTH - 1) ? DEPTH - 1 : post;
        for (int i = 0; i < stim_q.size(); i++) begin
            hit = is_match(stim_q[i], m, v);
`ifdef SAMPLE_CAPTURE_TRIG_EDGE_EN
            if (i > 0 && is_match(stim_q[i-1], m, v)) hit = 1'b0;
`endif
            if (hit) return i + lim + 1;
        end
        return -1;
    endfunction

    task automatic build_expected(int w);
        int start;
        exp_q.delete();
        start = (w > DEPTH) ? w - DEPTH : 0;
        for (int i = start; i < w; i++) exp_q.push_back(stim_q[i]);
    endtask

    // Feed all of stim_q with random gaps; stray ARM/READ_REQ only while capturing.
    task automatic capture(string tag, logic [7:0] m, logic [7:0] v, int post, int w,
                           int gap_mod);
        int stray = 0;
        TRIG_MASK = m; TRIG_VALUE = v; POST_COUNT = AW'(post);
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        foreach (stim_q[i]) begin
            while ($urandom_range(0, gap_mod) == 0) begin
                SAMPLE_VALID = 1'b0;
                ARM      = (i < w) && ($urandom_range(0, 15) == 0);
                READ_REQ = (i < w) && ($urandom_range(0, 7) == 0);
                tick();
                if (RD_VALID) stray++;
            end
            SAMPLE_VALID = 1'b1;
            SAMPLE_DIN   = stim_q[i];
            ARM      = (i < w) && ($urandom_range(0, 15) == 0);
            READ_REQ = (i < w) && ($urandom_range(0, 7) == 0);
            tick();
            if (RD_VALID) stray++;
        end
        SAMPLE_VALID = 1'b0; ARM = 1'b0; READ_REQ = 1'b0;
        tick();
        total++;
        if ({ARMED, TRIGGERED, DONE} !== 3'b011)
            $display("FAIL %s status: got %b required 011", tag, {ARMED, TRIGGERED, DONE});
        else passed++;
        total++;
        if (stray !== 0) $display("FAIL %s ignored_req: got %0d rd_valid cycles required 0",
                                  tag, stray);
        else passed++;
    endtask

    task automatic readout(string tag, int rdy_max);
        int n, budget, unstable, we_err, extra, bad, first_bad;
        bit prev_v, prev_r;
        logic [7:0] prev_d;
        n = exp_q.size();
        budget = 8 * n + 50;
        unstable = 0; we_err = 0; extra = 0; bad = 0; first_bad = -1;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'h00;
        got_q.delete();
        READ_REQ = 1'b1;
        tick();
        READ_REQ = 1'b0;
        for (int c = 0; c < budget && got_q.size() < n; c++) begin
            if (prev_v && !prev_r && (!RD_VALID || RD_DATA !== prev_d)) unstable++;
            if (MEM_WE) we_err++;
            RD_READY = ($urandom_range(0, rdy_max) != 0);
            if (RD_VALID && RD_READY) got_q.push_back(RD_DATA);
            prev_v = RD_VALID; prev_r = RD_READY; prev_d = RD_DATA;
            tick();
        end
        RD_READY = 1'b1;
        repeat (6) begin
            if (RD_VALID) extra++;
            tick();
        end
        RD_READY = 1'b0;
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        total++;
        if (got_q.size() !== n) $display("FAIL %s rd_len: got %0d words required %0d",
                                         tag, got_q.size(), n);
        else passed++;
        total++;
        if (bad !== 0) $display("FAIL %s rd_data: got %0d bad words, first at %0d (%h vs %h)",
                                tag, bad, first_bad, got_q[first_bad], exp_q[first_bad]);
        else passed++;
        total++;
        if (unstable !== 0) $display("FAIL %s rd_stable: got %0d changes required 0",
                                     tag, unstable);
        else passed++;
        total++;
        if ({extra, DONE, we_err} !== {32'd0, 1'b1, 32'd0})
            $display("FAIL %s rd_end: got extra=%0d done=%b we=%0d required 0/1/0",
                     tag, extra, DONE, we_err);
        else passed++;
    endtask

    function automatic logic [33:0] out_vec();
        return {RD_VALID, RD_DATA, MEM_ADDR, MEM_EN, MEM_WE, MEM_DIN, ARMED, TRIGGERED, DONE};
    endfunction

    task automatic make_ramp(int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(8'(i));
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        total++;
        if (out_vec() !== 34'd0) $display("FAIL reset outputs: got %h required 0", out_vec());
        else passed++;
        RST = 1'b0;
        tick();
    endtask

    task automatic test_ramp();
        int w;
        make_ramp(112);
        w = model_written(8'hFF, 8'h5A, 3);
        build_expected(w);
        capture("ramp", 8'hFF, 8'h5A, 3, w, 3);
        readout("ramp", 1);
        readout("ramp_again", 2);
    endtask

    task automatic test_arm_priority();
        int w;
        ARM = 1'b1; READ_REQ = 1'b1;
        tick();
        ARM = 1'b0; READ_REQ = 1'b0;
        total++;
        if ({ARMED, TRIGGERED, DONE, RD_VALID} !== 4'b1000)
            $display("FAIL arm_wins: got %b required 1000", {ARMED, TRIGGERED, DONE, RD_VALID});
        else passed++;
        tick();
        total++;
        if (MEM_EN !== 1'b0) $display("FAIL pre_idle_mem_en: got %b required 0", MEM_EN);
        else passed++;
        make_ramp(100);
        w = model_written(8'hFF, 8'h5A, 3);
        build_expected(w);
        capture("arm_wins", 8'hFF, 8'h5A, 3, w, 3);
        readout("arm_wins", 1);
    endtask

    task automatic test_trig_mode();
        int w;
        stim_q = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h05};
        w = model_written(8'h01, 8'h01, 0);
        build_expected(w);
        capture("trig_a", 8'h01, 8'h01, 0, w, 2);
        readout("trig_a", 1);
        stim_q = '{8'h00, 8'h01, 8'h01, 8'h00};
        w = model_written(8'h01, 8'h01, 0);
        build_expected(w);
        capture("trig_b", 8'h01, 8'h01, 0, w, 2);
        readout("trig_b", 1);
    endtask

    task automatic test_random();
        logic [7:0] m, v;
        int post, w;
        for (int it = 0; it < 8; it++) begin
            m = 8'(1 << $urandom_range(0, 7)) | (($urandom_range(0, 3) == 0) ? 8'h80 : 8'h00);
            v = 8'($urandom);
            post = $urandom_range(0, 20);
            stim_q.delete();
            for (int i = 0; i < 70; i++) stim_q.push_back(8'($urandom));
            w = model_written(m, v, post);
            if (w > 0 && w <= stim_q.size()) begin
                build_expected(w);
                capture("random", m, v, post, w, 3);
                readout("random", 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        make_ramp(100);
        TRIG_MASK = 8'hFF; TRIG_VALUE = 8'h5A; POST_COUNT = AW'(3);
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        for (int i = 0; i <= 8'h5B; i++) begin
            SAMPLE_VALID = 1'b1; SAMPLE_DIN = stim_q[i];
            tick();
        end
        RST = 1'b1;
        tick();
        total++;
        if (out_vec() !== 34'd0) $display("FAIL reset_post: got %h required 0", out_vec());
        else passed++;
        RST = 1'b0; SAMPLE_VALID = 1'b0;
        w = model_written(8'hFF, 8'h5A, 3);
        build_expected(w);
        capture("after_rst", 8'hFF, 8'h5A, 3, w, 3);
        READ_REQ = 1'b1;
        tick();
        READ_REQ = 1'b0; RD_READY = 1'b1;
        repeat (20) tick();
        RST = 1'b1;
        tick();
        total++;
        if (out_vec() !== 34'd0) $display("FAIL reset_read: got %h required 0", out_vec());
        else passed++;
        RST = 1'b0; RD_READY = 1'b0;
        READ_REQ = 1'b1;
        tick();
        READ_REQ = 1'b0;
        repeat (4) tick();
        total++;
        if ({RD_VALID, DONE} !== 2'b00) $display("FAIL idle_read_req: got %b required 00",
                                                  {RD_VALID, DONE});
        else passed++;
        capture("rearm", 8'hFF, 8'h5A, 3, w, 3);
        readout("rearm", 1);
    endtask

    task automatic test_clamp();
        TRIG_MASK = 8'h00; TRIG_VALUE = 8'h00; POST_COUNT = AW'(4000);
        ARM = 1'b1;
        tick();
        ARM = 1'b0;
        SAMPLE_VALID = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) begin
            SAMPLE_DIN = 8'($urandom);
            tick();
        end
        total++;
        if ({ARMED, DONE} !== 2'b10) $display("FAIL clamp_early: got %b required 10",
                                               {ARMED, DONE});
        else passed++;
        tick();
        SAMPLE_VALID = 1'b0;
        total++;
        if ({ARMED, DONE} !== 2'b01) $display("FAIL clamp_done: got %b required 01",
                                               {ARMED, DONE});
        else passed++;
    endtask

    task automatic test_full_wrap();
        int w;
        stim_q.delete();
        for (int i = 0; i < 3600; i++) stim_q.push_back(8'($urandom));
        w = model_written(8'h00, 8'h00, 3583);
        build_expected(w);
        capture("full", 8'h00, 8'h00, 3583, w, 7);
        readout("full", 3);
    endtask

    task automatic test_wrap_5000();
        int w;
        logic [7:0] s;
        stim_q.delete();
        for (int i = 0; i < 5000; i++) begin
            s = 8'($urandom);
            if (s == 8'hA5) s = 8'h00;
            stim_q.push_back(s);
        end
        for (int i = 0; i < 40; i++) stim_q.push_back(8'($urandom));
        stim_q[5000] = 8'hA5;
        w = model_written(8'hFF, 8'hA5, 10);
        build_expected(w);
        capture("wrap", 8'hFF, 8'hA5, 10, w, 7);
        readout("wrap", 3);
    endtask

    initial begin
        RST = 1'b0; ARM = 1'b0; SAMPLE_VALID = 1'b0; SAMPLE_DIN = 8'h00;
        TRIG_MASK = 8'h00; TRIG_VALUE = 8'h00; POST_COUNT = '0;
        READ_REQ = 1'b0; RD_READY = 1'b0;
        test_reset();
        test_ramp();
        test_arm_priority();
        test_trig_mode();
        test_random();
        test_reset_mid();
        test_clamp();
        test_full_wrap();
        test_wrap_5000();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
